// File: rtl/store_commit_ctrl.sv
// rtl/store_commit_ctrl.sv - retired-store queue with load/store RAM-port arbitration and deferred write-cache flush
module store_commit_ctrl #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     commit_valid,
  input  logic [31:0]              commit_addr,
  output logic                     commit_ready,
  input  logic                     ld_req,
  output logic                     ld_grant,
  input  logic                     mem_ack,
  output logic                     store_ready,
  output logic [31:0]              retired_address,
  input  logic                     flush_req,
  output logic                     wc_flush,
  output logic                     flush_stall,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;

  state_t          state_q, state_d;
  logic [31:0]     mem_q [DEPTH];
  logic [31:0]     mem_d [DEPTH];
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            flush_pending_q, flush_pending_d;
  logic            wc_flush_q, wc_flush_d;

  logic            store_wins;
  logic            wins_after_pop;
  logic            push;
  logic            pop;

  // Arbitration: a queued store beats loads when no load asks, the queue is full, or loads have starved it long enough
  always_comb begin
    store_wins     = (count_q != '0) &&
                     (!ld_req || count_q == CW'(DEPTH) || starve_q >= SW'(STARVE_MAX));
    // After a pop the queue cannot be full, and starve_q was cleared when this store issued
    wins_after_pop = (count_q != CW'(1)) && (!ld_req || starve_q >= SW'(STARVE_MAX));
  end

  // State register plus all queue, starvation and flush bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      starve_q        <= '0;
      flush_pending_q <= 1'b0;
      wc_flush_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q         <= state_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      starve_q        <= starve_d;
      flush_pending_q <= flush_pending_d;
      wc_flush_q      <= wc_flush_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Next-state logic for the store issue machine
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (store_wins) state_d = ISSUE;
      ISSUE:    state_d = WAIT_ACK;
      WAIT_ACK: if (mem_ack) state_d = wins_after_pop ? ISSUE : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs; everything is forced quiet while rst is high so a mid-store reset never shows a store_ready
  always_comb begin
    commit_ready    = !rst && (count_q < CW'(DEPTH)) && !flush_pending_q;
    store_ready     = !rst && (state_q == ISSUE);
    retired_address = (!rst && state_q == ISSUE) ? mem_q[head_q] : 32'h0;
    ld_grant        = !rst && ld_req && (state_q == IDLE) && !store_wins;
    flush_stall     = !rst && flush_pending_q;
    wc_flush        = !rst && wc_flush_q;
    q_count         = rst ? '0 : count_q;
  end

  // Queue push/pop, starvation counter and flush deferral
  always_comb begin
    push = commit_valid && commit_ready;
    pop  = (state_q == WAIT_ACK) && mem_ack;

    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (push) mem_d[tail_q] = commit_addr;

    tail_d  = push ? tail_q + AW'(1) : tail_q;
    head_d  = pop  ? head_q + AW'(1) : head_q;
    count_d = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    if (!push && pop) count_d = count_q - CW'(1);

    starve_d = starve_q;
    if (state_d == ISSUE && state_q != ISSUE)
      starve_d = '0;
    else if (count_q != '0 && ld_grant && starve_q < SW'(STARVE_MAX))
      starve_d = starve_q + SW'(1);

    // The write cache is flushed only once every retired store has reached the RAM
    wc_flush_d      = flush_pending_q && (count_q == '0) && (state_q == IDLE);
    flush_pending_d = flush_pending_q;
    if (wc_flush_d)
      flush_pending_d = 1'b0;
    else if (flush_req)
      flush_pending_d = 1'b1;
  end

endmodule

// File: tb/tb_store_commit_ctrl.sv
// tb/tb_store_commit_ctrl.sv - directed self-checking bench for store_commit_ctrl
module tb_store_commit_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid;
  logic [31:0] commit_addr;
  logic        commit_ready;
  logic        ld_req;
  logic        ld_grant;
  logic        mem_ack;
  logic        store_ready;
  logic [31:0] retired_address;
  logic        flush_req;
  logic        wc_flush;
  logic        flush_stall;
  logic [2:0]  q_count;

  int n_tests = 0;
  int n_fail  = 0;

  store_commit_ctrl #(.DEPTH(4), .STARVE_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_addr(commit_addr), .commit_ready(commit_ready),
    .ld_req(ld_req), .ld_grant(ld_grant), .mem_ack(mem_ack),
    .store_ready(store_ready), .retired_address(retired_address),
    .flush_req(flush_req), .wc_flush(wc_flush), .flush_stall(flush_stall),
    .q_count(q_count)
  );

  always #5 clk = ~clk;

  // Advance to 1ns after the next rising edge; inputs are changed there and outputs sampled 1ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    commit_valid = 1'b0;
    commit_addr  = 32'h0;
    ld_req       = 1'b0;
    mem_ack      = 1'b0;
    flush_req    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    #1;
    n_tests++;
    if ({commit_ready, store_ready, wc_flush, flush_stall, ld_grant} !== 5'b0 ||
        retired_address !== 32'h0 || q_count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_during: cr=%b sr=%b wf=%b fs=%b lg=%b ra=%h qc=%0d, required all 0",
               commit_ready, store_ready, wc_flush, flush_stall, ld_grant, retired_address, q_count);
    end
    rst = 1'b0;
    tick();
    #1;
    n_tests++;
    if (commit_ready !== 1'b1 || {store_ready, wc_flush, flush_stall, ld_grant} !== 4'b0 ||
        retired_address !== 32'h0 || q_count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_after: cr=%b sr=%b wf=%b fs=%b lg=%b ra=%h qc=%0d, required cr=1 others 0",
               commit_ready, store_ready, wc_flush, flush_stall, ld_grant, retired_address, q_count);
    end
  endtask

  task automatic test_single_store();
    do_reset();
    commit_valid = 1'b1; commit_addr = 32'h10;     // cycle 0
    tick();
    idle_inputs();                                  // cycle 1: IDLE, queue 1
    #1;
    n_tests++;
    if (q_count !== 3'd1 || store_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_c1: qc=%0d sr=%b, required qc=1 sr=0", q_count, store_ready);
    end
    tick();                                         // cycle 2: ISSUE
    #1;
    n_tests++;
    if (store_ready !== 1'b1 || retired_address !== 32'h10) begin
      n_fail++;
      $display("FAIL single_issue: sr=%b ra=%h, required sr=1 ra=00000010", store_ready, retired_address);
    end
    tick();                                         // cycle 3: WAIT_ACK
    #1;
    n_tests++;
    if (store_ready !== 1'b0 || retired_address !== 32'h0 || q_count !== 3'd1) begin
      n_fail++;
      $display("FAIL single_wait: sr=%b ra=%h qc=%0d, required sr=0 ra=0 qc=1", store_ready, retired_address, q_count);
    end
    tick();                                         // cycle 4: ack
    mem_ack = 1'b1;
    tick();                                         // cycle 5
    mem_ack = 1'b0;
    #1;
    n_tests++;
    if (q_count !== 3'd0 || store_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pop: qc=%0d sr=%b, required qc=0 sr=0", q_count, store_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] seen [$];
    logic        ready_ok;
    do_reset();
    ready_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      commit_valid = 1'b1; commit_addr = 32'(i + 1);
      #1;
      if (commit_ready !== 1'b1) ready_ok = 1'b0;
      if (store_ready === 1'b1) seen.push_back(retired_address);
      tick();
    end
    commit_valid = 1'b1; commit_addr = 32'h77;
    #1;
    n_tests++;
    if (ready_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready_fill: commit_ready dropped while filling, required 1");
    end
    n_tests++;
    if (commit_ready !== 1'b0 || q_count !== 3'd4) begin
      n_fail++;
      $display("FAIL b2b_full: cr=%b qc=%0d, required cr=0 qc=4", commit_ready, q_count);
    end
    if (store_ready === 1'b1) seen.push_back(retired_address);
    tick();
    commit_valid = 1'b0;
    mem_ack = 1'b1;
    for (int c = 0; c < 30 && q_count !== 3'd0; c++) begin
      #1;
      if (store_ready === 1'b1) seen.push_back(retired_address);
      tick();
    end
    mem_ack = 1'b0;
    n_tests++;
    if (seen.size() !== 4) begin
      n_fail++;
      $display("FAIL b2b_count: %0d stores issued, required 4", seen.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (seen[i] !== 32'(i + 1)) begin
          n_fail++;
          $display("FAIL b2b_order[%0d]: ra=%h, required %h", i, seen[i], 32'(i + 1));
        end
      end
    end
    n_tests++;
    if (q_count !== 3'd0) begin
      n_fail++;
      $display("FAIL b2b_drain: qc=%0d, required 0", q_count);
    end
  endtask

  task automatic test_starve();
    int   grants;
    logic found;
    logic [31:0] addr;
    do_reset();
    commit_valid = 1'b1; commit_addr = 32'h55;
    tick();
    commit_valid = 1'b0;
    ld_req = 1'b1;
    grants = 0;
    found = 1'b0;
    addr = 32'h0;
    for (int c = 0; c < 40 && !found; c++) begin
      #1;
      if (store_ready === 1'b1) begin
        found = 1'b1;
        addr = retired_address;
      end else begin
        if (ld_grant === 1'b1) grants++;
        tick();
      end
    end
    n_tests++;
    if (!found || grants !== 8 || addr !== 32'h55) begin
      n_fail++;
      $display("FAIL starve_grants: found=%b grants=%0d ra=%h, required found=1 grants=8 ra=00000055",
               found, grants, addr);
    end
    tick();                                         // WAIT_ACK
    #1;
    n_tests++;
    if (ld_grant !== 1'b0) begin
      n_fail++;
      $display("FAIL starve_wait_grant: lg=%b, required 0", ld_grant);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    #1;
    n_tests++;
    if (ld_grant !== 1'b1 || q_count !== 3'd0) begin
      n_fail++;
      $display("FAIL starve_resume: lg=%b qc=%0d, required lg=1 qc=0", ld_grant, q_count);
    end
    ld_req = 1'b0;
  endtask

  task automatic test_flush();
    int   pulses;
    int   issues_before;
    int   issues;
    logic bad_pulse;
    do_reset();
    commit_valid = 1'b1; commit_addr = 32'hA;
    tick();
    commit_addr = 32'hB; flush_req = 1'b1;
    tick();
    commit_valid = 1'b0; flush_req = 1'b0;
    #1;
    n_tests++;
    if (flush_stall !== 1'b1 || commit_ready !== 1'b0 || q_count !== 3'd2) begin
      n_fail++;
      $display("FAIL flush_stall: fs=%b cr=%b qc=%0d, required fs=1 cr=0 qc=2", flush_stall, commit_ready, q_count);
    end
    mem_ack = 1'b1;
    pulses = 0; issues = 0; issues_before = -1; bad_pulse = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (store_ready === 1'b1) issues++;
      if (wc_flush === 1'b1) begin
        pulses++;
        if (issues_before < 0) issues_before = issues;
        if (q_count !== 3'd0) bad_pulse = 1'b1;
      end
      tick();
    end
    mem_ack = 1'b0;
    n_tests++;
    if (pulses !== 1 || issues_before !== 2 || bad_pulse) begin
      n_fail++;
      $display("FAIL flush_pulse: pulses=%0d stores_before=%0d nonempty=%b, required 1 pulse after 2 stores with empty queue",
               pulses, issues_before, bad_pulse);
    end
    #1;
    n_tests++;
    if (flush_stall !== 1'b0 || commit_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_release: fs=%b cr=%b, required fs=0 cr=1", flush_stall, commit_ready);
    end
    // Empty queue: flush_req in cycle 0 gives wc_flush in cycle 2
    tick();
    flush_req = 1'b1;
    #1;
    n_tests++;
    if (wc_flush !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_empty_c0: wf=%b, required 0", wc_flush);
    end
    tick();
    flush_req = 1'b0;
    #1;
    n_tests++;
    if (wc_flush !== 1'b0 || flush_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_empty_c1: wf=%b fs=%b, required wf=0 fs=1", wc_flush, flush_stall);
    end
    tick();
    #1;
    n_tests++;
    if (wc_flush !== 1'b1 || flush_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_empty_c2: wf=%b fs=%b, required wf=1 fs=0", wc_flush, flush_stall);
    end
    tick();
    #1;
    n_tests++;
    if (wc_flush !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_empty_c3: wf=%b, required 0", wc_flush);
    end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      commit_valid = 1'b1; commit_addr = 32'(8'h30 + i);
      tick();
    end
    commit_valid = 1'b0;                            // cycle 3: WAIT_ACK with 3 entries
    #1;
    n_tests++;
    if (q_count !== 3'd3 || store_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rstwait_pre: qc=%0d sr=%b, required qc=3 sr=0", q_count, store_ready);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_ack = 1'b1;
    #1;
    n_tests++;
    if (q_count !== 3'd0 || {store_ready, wc_flush, flush_stall, ld_grant} !== 4'b0 ||
        retired_address !== 32'h0 || commit_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstwait_after: qc=%0d sr=%b wf=%b fs=%b lg=%b ra=%h cr=%b, required qc=0 outputs 0 cr=1",
               q_count, store_ready, wc_flush, flush_stall, ld_grant, retired_address, commit_ready);
    end
    tick();
    mem_ack = 1'b0;
    ld_req = 1'b1;
    #1;
    n_tests++;
    if (q_count !== 3'd0 || store_ready !== 1'b0 || ld_grant !== 1'b1) begin
      n_fail++;
      $display("FAIL rstwait_late_ack: qc=%0d sr=%b lg=%b, required qc=0 sr=0 lg=1", q_count, store_ready, ld_grant);
    end
    ld_req = 1'b0;
  endtask

  task automatic test_full_drop();
    logic [31:0] seen [$];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      commit_valid = 1'b1; commit_addr = 32'(8'h21 + i);
      tick();
    end
    commit_valid = 1'b1; commit_addr = 32'h99;      // full, WAIT_ACK on 0x21
    mem_ack = 1'b1;
    #1;
    n_tests++;
    if (commit_ready !== 1'b0 || q_count !== 3'd4) begin
      n_fail++;
      $display("FAIL full_drop_ready: cr=%b qc=%0d, required cr=0 qc=4", commit_ready, q_count);
    end
    tick();
    commit_valid = 1'b0;
    #1;
    n_tests++;
    if (q_count !== 3'd3) begin
      n_fail++;
      $display("FAIL full_drop_count: qc=%0d, required 3", q_count);
    end
    for (int c = 0; c < 20 && q_count !== 3'd0; c++) begin
      #1;
      if (store_ready === 1'b1) seen.push_back(retired_address);
      tick();
    end
    mem_ack = 1'b0;
    n_tests++;
    if (seen.size() !== 3) begin
      n_fail++;
      $display("FAIL full_drop_drain: %0d stores, required 3", seen.size());
    end else begin
      n_tests++;
      if (seen[0] !== 32'h22 || seen[1] !== 32'h23 || seen[2] !== 32'h24) begin
        n_fail++;
        $display("FAIL full_drop_order: %h %h %h, required 22 23 24", seen[0], seen[1], seen[2]);
      end
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_single_store();
    test_back_to_back();
    test_starve();
    test_flush();
    test_reset_in_wait();
    test_full_drop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
